// File: rtl/cic_decimator_if.sv
// Sample-stream bundle between the notch stage, the CIC decimator and its consumer.
interface cic_decimator_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] x_in;
  logic [2:0]            dec_sel;
  logic [DATA_WIDTH-1:0] x_out;
  logic                  valid_out;
  logic                  cfg_err;

  // Source side: drives samples and configuration, observes results.
  modport master (
    output valid_in, x_in, dec_sel,
    input  x_out, valid_out, cfg_err
  );

  // Decimator side.
  modport slave (
    input  valid_in, x_in, dec_sel,
    output x_out, valid_out, cfg_err
  );
endinterface

// File: rtl/cic_decimator.sv
// Runtime-configurable CIC decimator (R = 2^dec_sel, N integrator/comb stages,
// M = 1) with gain renormalisation, round half-up and output saturation.
module cic_decimator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_STAGES   = 5,
  parameter int unsigned LOG2_MAXR  = 4,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + N_STAGES * LOG2_MAXR
) (
  input  logic            clk,
  input  logic            rst_n,
  cic_decimator_if.slave  bus
);

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned PH_W   = LOG2_MAXR;
  localparam int unsigned WARM_W = $clog2(N_STAGES + 1);
  localparam int unsigned EXT_W  = ACC_WIDTH + 1;

  localparam logic [SEL_W-1:0]       MAX_SEL  = SEL_W'(LOG2_MAXR);
  localparam logic [WARM_W-1:0]      WARM_END = WARM_W'(N_STAGES - 1);
  localparam logic signed [EXT_W-1:0] RND_ONE = EXT_W'(1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - RND_ONE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WARM     = 2'd1,
    RUN      = 2'd2,
    RECONFIG = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [SEL_W-1:0]             r_cur_q, r_cur_d;
  logic [SEL_W-1:0]             r_new_q, r_new_d;
  logic                         cfg_err_q, cfg_err_d;
  logic [PH_W-1:0]              phase_q, phase_d;
  logic [WARM_W-1:0]            warm_q, warm_d;
  logic signed [ACC_WIDTH-1:0]  integ_q [N_STAGES];
  logic signed [ACC_WIDTH-1:0]  integ_d [N_STAGES];
  logic signed [ACC_WIDTH-1:0]  cdly_q  [N_STAGES];
  logic signed [ACC_WIDTH-1:0]  cdly_d  [N_STAGES];
  logic signed [ACC_WIDTH-1:0]  comb_q, comb_d;
  logic                         dec_q, dec_d;
  logic                         dsup_q, dsup_d;
  logic                         out_q, out_d;
  logic                         osup_q, osup_d;
  logic [DATA_WIDTH-1:0]        x_out_q, x_out_d;
  logic                         valid_out_q, valid_out_d;

  logic                         legal;
  logic                         accept;
  logic [SEL_W-1:0]             r_eff;
  logic [PH_W-1:0]              last_ph;
  logic signed [ACC_WIDTH-1:0]  carry;
  logic signed [ACC_WIDTH-1:0]  c;
  logic signed [ACC_WIDTH-1:0]  diff;
  logic signed [EXT_W-1:0]      rnd;
  logic signed [EXT_W-1:0]      shd;
  int unsigned                  sh;

  // Next-state, integrate / decimate / comb / scale datapath.
  always_comb begin
    state_d     = state_q;
    r_cur_d     = r_cur_q;
    r_new_d     = r_new_q;
    cfg_err_d   = cfg_err_q;
    phase_d     = phase_q;
    warm_d      = warm_q;
    integ_d     = integ_q;
    cdly_d      = cdly_q;
    comb_d      = comb_q;
    dec_d       = 1'b0;
    dsup_d      = 1'b0;
    out_d       = 1'b0;
    osup_d      = 1'b0;
    x_out_d     = x_out_q;
    valid_out_d = 1'b0;
    accept      = 1'b0;
    r_eff       = r_cur_q;
    last_ph     = '0;
    carry       = '0;
    c           = '0;
    diff        = '0;
    rnd         = '0;
    shd         = '0;
    sh          = 0;

    legal = (bus.dec_sel <= MAX_SEL);
    if (!legal) cfg_err_d = 1'b1;

    // Control: configuration tracking and sample acceptance.
    case (state_q)
      IDLE: begin
        if (legal) begin
          r_cur_d = bus.dec_sel;
          r_eff   = bus.dec_sel;
        end
        if (bus.valid_in) begin
          accept  = 1'b1;
          state_d = WARM;
        end
      end
      WARM, RUN: begin
        if (legal && (bus.dec_sel != r_cur_q)) begin
          state_d = RECONFIG;
          r_new_d = bus.dec_sel;
        end else begin
          accept = bus.valid_in;
        end
      end
      RECONFIG: begin
        r_cur_d = r_new_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Integrator cascade and phase counter; the decimating sample is tagged
    // as suppressed while the comb transient is still flushing.
    if (accept) begin
      carry = ACC_WIDTH'($signed(bus.x_in));
      for (int k = 0; k < int'(N_STAGES); k++) begin
        integ_d[k] = integ_q[k] + carry;
        carry      = integ_d[k];
      end
      last_ph = PH_W'((32'd1 << r_eff) - 32'd1);
      if (phase_q == last_ph) begin
        phase_d = '0;
        dec_d   = 1'b1;
        if (state_q != RUN) begin
          dsup_d = 1'b1;
          warm_d = warm_q + WARM_W'(1);
          if (warm_q == WARM_END) state_d = RUN;
        end
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end

    // Comb cascade, evaluated the cycle after a decimating sample.
    if (dec_q) begin
      c = integ_q[N_STAGES-1];
      for (int k = 0; k < int'(N_STAGES); k++) begin
        diff      = c - cdly_q[k];
        cdly_d[k] = c;
        c         = diff;
      end
      comb_d = c;
      out_d  = 1'b1;
      osup_d = dsup_q;
    end

    // Gain renormalisation by 2^(N*dec_sel), round half-up, saturate.
    if (out_q) begin
      sh  = N_STAGES * 32'(r_cur_q);
      rnd = EXT_W'(comb_q);
      if (sh != 0) rnd = rnd + (RND_ONE <<< (sh - 1));
      shd = rnd >>> sh;
      if (shd > SAT_MAX)      shd = SAT_MAX;
      else if (shd < SAT_MIN) shd = SAT_MIN;
      if (!osup_q) begin
        x_out_d     = DATA_WIDTH'(shd);
        valid_out_d = 1'b1;
      end
    end

    // Reconfiguration flushes all filter state and anything in flight.
    if (state_q == RECONFIG) begin
      for (int k = 0; k < int'(N_STAGES); k++) begin
        integ_d[k] = '0;
        cdly_d[k]  = '0;
      end
      comb_d      = '0;
      phase_d     = '0;
      warm_d      = '0;
      dec_d       = 1'b0;
      out_d       = 1'b0;
      valid_out_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_q     <= '0;
      r_new_q     <= '0;
      cfg_err_q   <= 1'b0;
      phase_q     <= '0;
      warm_q      <= '0;
      for (int k = 0; k < int'(N_STAGES); k++) begin
        integ_q[k] <= '0;
        cdly_q[k]  <= '0;
      end
      comb_q      <= '0;
      dec_q       <= 1'b0;
      dsup_q      <= 1'b0;
      out_q       <= 1'b0;
      osup_q      <= 1'b0;
      x_out_q     <= '0;
      valid_out_q <= 1'b0;
    end else begin
      r_cur_q     <= r_cur_d;
      r_new_q     <= r_new_d;
      cfg_err_q   <= cfg_err_d;
      phase_q     <= phase_d;
      warm_q      <= warm_d;
      integ_q     <= integ_d;
      cdly_q      <= cdly_d;
      comb_q      <= comb_d;
      dec_q       <= dec_d;
      dsup_q      <= dsup_d;
      out_q       <= out_d;
      osup_q      <= osup_d;
      x_out_q     <= x_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.x_out     = x_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: reset, R=1 ramp, DC gain at R=4/16,
// back-to-back random R=2 against a sample-level model, reconfig, cfg_err, reset flush.
module tb_cic_decimator;

  localparam int unsigned DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cic_decimator_if #(.DATA_WIDTH(DW)) bus ();

  cic_decimator #(.DATA_WIDTH(DW), .N_STAGES(5), .LOG2_MAXR(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  logic [15:0] obs_q[$];
  longint      obs_t[$];
  logic [15:0] exp_q[$];

  // Reference model state (sample-level, 36-bit modular)
  longint mi[5];
  longint mc[5];
  int     mph;
  int     mdec;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      obs_q.push_back(bus.x_out);
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input int gap);
    bus.valid_in = 1'b1;
    bus.x_in     = x;
    tick();
    bus.valid_in = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic do_reset(input logic [2:0] sel);
    bus.valid_in = 1'b0;
    bus.dec_sel  = sel;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_t.delete();
  endtask

  // Request a new legal R from RUN with no sample pending; lands in IDLE.
  task automatic reconfig(input logic [2:0] sel);
    bus.dec_sel = sel;
    tick();
    tick();
    tick();
    chk("reconfig_idle", longint'(dut.state_q), 0);
  endtask

  // DC run: n samples every 3 clk, expect n_out outputs of value v.
  task automatic dc_run(input string tag, input logic [15:0] v, input int n,
                        input int r_log, input int n_out);
    longint t0;
    int     r;
    r = 1 << r_log;
    clear_obs();
    t0 = cyc;
    for (int i = 0; i < n; i++) send(v, 3);
    repeat (3) tick();
    chk({tag, "_count"}, obs_q.size(), n_out);
    if (obs_q.size() > 0)
      chk({tag, "_first_time"}, obs_t[0] - t0, 3 + 3 * (6 * r - 1));
    foreach (obs_q[i]) chk({tag, "_value"}, obs_q[i], v);
    for (int i = 1; i < obs_t.size(); i++)
      chk({tag, "_spacing"}, obs_t[i] - obs_t[i-1], 3 * r);
  endtask

  function automatic longint w36(input longint v);
    return (v <<< 28) >>> 28;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      mi[k] = 0;
      mc[k] = 0;
    end
    mph  = 0;
    mdec = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [15:0] x, input int r_log);
    longint cc, t, v;
    int     sh;
    mi[0] = w36(mi[0] + longint'($signed(x)));
    for (int k = 1; k < 5; k++) mi[k] = w36(mi[k] + mi[k-1]);
    mph++;
    if (mph == (1 << r_log)) begin
      mph = 0;
      cc  = mi[4];
      for (int k = 0; k < 5; k++) begin
        t     = w36(cc - mc[k]);
        mc[k] = cc;
        cc    = t;
      end
      sh = 5 * r_log;
      v  = cc;
      if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
      v = v >>> sh;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      if (mdec >= 5) exp_q.push_back(16'(v));
      mdec++;
    end
  endtask

  initial begin
    logic [15:0] x;
    bus.valid_in = 1'b0;
    bus.x_in     = '0;
    bus.dec_sel  = '0;

    // T1: reset held with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.valid_in = 1'($urandom);
      bus.x_in     = 16'($urandom);
      bus.dec_sel  = 3'($urandom);
      tick();
      chk("rst_x_out", bus.x_out, 0);
      chk("rst_valid_out", bus.valid_out, 0);
      chk("rst_cfg_err", bus.cfg_err, 0);
      chk("rst_state", longint'(dut.state_q), 0);
    end
    bus.valid_in = 1'b0;
    bus.dec_sel  = 3'd0;
    rst_n = 1'b1;
    tick();

    // T2: R=1 ramp, 5 suppressed outputs then identity with 2-clk latency
    for (int i = 0; i < 12; i++) begin
      bus.valid_in = 1'b1;
      bus.x_in     = 16'(i);
      tick();
      bus.valid_in = 1'b0;
      tick();
      chk("r1_mid_valid", bus.valid_out, 0);
      tick();
      chk("r1_valid", bus.valid_out, (i >= 5) ? 1 : 0);
      chk("r1_x_out", bus.x_out, (i >= 5) ? i : 0);
    end

    // T3: DC gain at R=4 and R=16
    reconfig(3'd2);
    dc_run("dc4000_r4", 16'h4000, 40, 2, 5);
    reconfig(3'd4);
    dc_run("dc8000_r16", 16'h8000, 128, 4, 3);
    do_reset(3'd4);
    dc_run("dc7fff_r16", 16'h7FFF, 128, 4, 3);

    // T4: back-to-back random samples at R=2 against the model
    do_reset(3'd1);
    model_reset();
    clear_obs();
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      bus.valid_in = 1'b1;
      bus.x_in     = x;
      model_step(x, 1);
      tick();
    end
    bus.valid_in = 1'b0;
    repeat (5) tick();
    chk("b2b_count", obs_q.size(), exp_q.size());
    chk("b2b_expected_count", exp_q.size(), 495);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk("b2b_value", obs_q[i], exp_q[i]);
    for (int i = 1; i < obs_t.size(); i++)
      chk("b2b_spacing", obs_t[i] - obs_t[i-1], 2);

    // T5: dec_sel 2->3 coincident with valid_in in RUN
    do_reset(3'd2);
    dc_run("pre_reconfig", 16'h4000, 40, 2, 5);
    bus.dec_sel  = 3'd3;
    bus.valid_in = 1'b1;
    bus.x_in     = 16'h4000;
    tick();
    bus.valid_in = 1'b0;
    chk("t5_state_reconfig", longint'(dut.state_q), 3);
    tick();
    chk("t5_state_idle", longint'(dut.state_q), 0);
    chk("t5_r_cur", longint'(dut.r_cur_q), 3);
    tick();
    dc_run("dc4000_r8", 16'h4000, 56, 3, 2);

    // T6: illegal dec_sel is ignored but sticky; reset flushes in-flight output
    reconfig(3'd2);
    dc_run("t6_warm", 16'h4000, 40, 2, 5);
    bus.dec_sel = 3'd6;
    clear_obs();
    for (int i = 0; i < 16; i++) send(16'h4000, 3);
    repeat (3) tick();
    chk("t6_cfg_err", bus.cfg_err, 1);
    chk("t6_r_cur", longint'(dut.r_cur_q), 2);
    chk("t6_state_run", longint'(dut.state_q), 2);
    chk("t6_count", obs_q.size(), 4);
    foreach (obs_q[i]) chk("t6_value", obs_q[i], 16'h4000);
    bus.dec_sel = 3'd2;
    tick();
    chk("t6_cfg_err_sticky", bus.cfg_err, 1);
    clear_obs();
    for (int i = 0; i < 3; i++) send(16'h4000, 3);
    bus.valid_in = 1'b1;
    bus.x_in     = 16'h4000;
    tick();
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    tick();
    tick();
    chk("t6_rst_valid", bus.valid_out, 0);
    chk("t6_rst_x_out", bus.x_out, 0);
    chk("t6_rst_cfg_err", bus.cfg_err, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t6_no_stray", obs_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
